// File: rtl/pol2rec_pkg.sv
// Shared constants, formats and state encoding for the polar-to-rectangular CORDIC.
// Gain compensation is enabled by defining POL2REC_GAIN_COMP_EN.
package pol2rec_pkg;

  localparam int unsigned NiterDefault = 32;

  // 16Q16 modulus / X / Y, 8Q24 angle in degrees
  localparam int unsigned ModW     = 32;
  localparam int unsigned ModFracW = 16;
  localparam int unsigned AngW     = 32;
  localparam int unsigned AngFracW = 24;
  localparam int unsigned IterW    = 5;

  // 1/K in 1Q31
  localparam logic signed [ModW-1:0] Kinv = 32'sh4DBA76D4;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Pre-scales the modulus by 1/K so the rotated vector leaves with unit gain.
  function automatic logic signed [ModW-1:0] gain_comp(input logic signed [ModW-1:0] m);
    logic signed [2*ModW-1:0] prod;
    prod = (2*ModW)'(m) * (2*ModW)'(Kinv);
    return ModW'(prod >>> 31);
  endfunction

endpackage

// File: rtl/pol2rec_atan_rom.sv
// atan(2^-i) in degrees, 8Q24, indexed by the CORDIC iteration number.
module pol2rec_atan_rom
  import pol2rec_pkg::*;
(
  input  logic [IterW-1:0] addr,
  output logic [AngW-1:0]  atan
);

  always_comb begin
    atan = '0;
    unique case (addr)
      5'd0:  atan = 32'h2D000000;
      5'd1:  atan = 32'h1A90A732;
      5'd2:  atan = 32'h0E094740;
      5'd3:  atan = 32'h07200112;
      5'd4:  atan = 32'h03938AA6;
      5'd5:  atan = 32'h01CA3795;
      5'd6:  atan = 32'h00E52A1B;
      5'd7:  atan = 32'h007296D8;
      5'd8:  atan = 32'h00394BA5;
      5'd9:  atan = 32'h001CA5DA;
      5'd10: atan = 32'h000E52EE;
      5'd11: atan = 32'h00072977;
      5'd12: atan = 32'h000394BC;
      5'd13: atan = 32'h0001CA5E;
      5'd14: atan = 32'h0000E52F;
      5'd15: atan = 32'h00007297;
      5'd16: atan = 32'h0000394C;
      5'd17: atan = 32'h00001CA6;
      5'd18: atan = 32'h00000E53;
      5'd19: atan = 32'h00000729;
      5'd20: atan = 32'h00000395;
      5'd21: atan = 32'h000001CA;
      5'd22: atan = 32'h000000E5;
      5'd23: atan = 32'h00000073;
      5'd24: atan = 32'h00000039;
      5'd25: atan = 32'h0000001D;
      5'd26: atan = 32'h0000000E;
      5'd27: atan = 32'h00000007;
      5'd28: atan = 32'h00000004;
      5'd29: atan = 32'h00000002;
      5'd30: atan = 32'h00000001;
      5'd31: atan = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/pol2rec.sv
// Serial CORDIC (rotation mode): polar (16Q16 modulus, 8Q24 degrees) to rectangular 16Q16.
// Define POL2REC_GAIN_COMP_EN to pre-scale the modulus by 1/K; otherwise outputs carry gain K.
module pol2rec
  import pol2rec_pkg::*;
#(
  parameter int unsigned NITER = NiterDefault
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic signed [ModW-1:0] mod,
  input  logic signed [AngW-1:0] angle,
  output logic signed [ModW-1:0] x,
  output logic signed [ModW-1:0] y,
  output logic                   done
);

  state_e                 state_q, state_d;
  logic [IterW-1:0]       iter_q, iter_d;
  logic signed [ModW-1:0] xr_q, xr_d, yr_q, yr_d;
  logic signed [AngW-1:0] zr_q, zr_d;
  logic signed [ModW-1:0] x_q, x_d, y_q, y_d;
  logic                   done_q, done_d;

  logic signed [ModW-1:0] x0;
  logic [AngW-1:0]        atan_i;
  logic signed [ModW-1:0] xs, ys, xr_nx, yr_nx;
  logic signed [AngW-1:0] zr_nx;
  logic                   last_iter;

`ifdef POL2REC_GAIN_COMP_EN
  assign x0 = gain_comp(mod);
`else
  assign x0 = mod;
`endif

  pol2rec_atan_rom u_atan_rom (
    .addr (iter_q),
    .atan (atan_i)
  );

  assign xs        = xr_q >>> iter_q;
  assign ys        = yr_q >>> iter_q;
  assign last_iter = (iter_q == IterW'(NITER - 1));

  // One micro-rotation; direction chosen to drive the residual angle toward zero.
  always_comb begin
    if (!zr_q[AngW-1]) begin
      xr_nx = xr_q - ys;
      yr_nx = yr_q + xs;
      zr_nx = zr_q - $signed(atan_i);
    end else begin
      xr_nx = xr_q + ys;
      yr_nx = yr_q - xs;
      zr_nx = zr_q + $signed(atan_i);
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    zr_d    = zr_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = done_q;

    if (start) begin
      // Load wins over iteration and ignores enable; outputs keep the previous result.
      state_d = StRun;
      iter_d  = '0;
      xr_d    = x0;
      yr_d    = '0;
      zr_d    = angle;
      done_d  = 1'b0;
    end else if (state_q == StRun && enable) begin
      xr_d   = xr_nx;
      yr_d   = yr_nx;
      zr_d   = zr_nx;
      iter_d = iter_q + IterW'(1);
      if (last_iter) begin
        x_d     = xr_nx;
        y_d     = yr_nx;
        done_d  = 1'b1;
        state_d = StIdle;
        iter_d  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
      zr_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      zr_q    <= zr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign done = done_q;

endmodule

// File: tb/tb_pol2rec.sv
// Directed bench for pol2rec: reference vectors, latency, enable stall, restart and reset.
module tb_pol2rec;

`ifdef POL2REC_GAIN_COMP_EN
  localparam real Gain = 1.0;
  localparam longint Tol = 8;
`else
  localparam real Gain = 1.646760258;
  localparam longint Tol = 16;
`endif

  localparam real Cos30 = 0.8660254037844386;
  localparam real Rt2   = 1.4142135623730951;

  logic               clock;
  logic               reset;
  logic               enable;
  logic               start;
  logic signed [31:0] mod;
  logic signed [31:0] angle;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;

  pol2rec dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .mod    (mod),
    .angle  (angle),
    .x      (x),
    .y      (y),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    diff = got - exp;
    n_tests++;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), want %0d +/- %0d", tag, got, got[31:0], exp, tol);
    end
  endtask

  // Real-valued coordinate to 16Q16, including the build's CORDIC gain.
  function automatic longint q16(input real r);
    real v;
    v = r * 65536.0 * Gain;
    return longint'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done; optionally drops enable for a window.
  task automatic wait_done(input int gap_at, input int gap_len, output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
      if (cycles == gap_at) enable = 1'b0;
      if (cycles == gap_at + gap_len) enable = 1'b1;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] m, input logic [31:0] a,
                         input real ex, input real ey);
    int cyc;
    mod   = m;
    angle = a;
    pulse_start();
    check({tag, "_done_at_load"}, longint'(done), 0, 0);
    wait_done(-1, 0, cyc);
    check({tag, "_latency"}, cyc, 32, 0);
    check({tag, "_x"}, longint'(x), q16(ex), Tol);
    check({tag, "_y"}, longint'(y), q16(ey), Tol);
  endtask

  initial begin
    int cyc;
    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    mod    = '0;
    angle  = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_x", longint'(x), 0, 0);
    check("reset_y", longint'(y), 0, 0);
    check("reset_done", longint'(done), 0, 0);

    run_vec("unit_0", 32'h00010000, 32'h00000000, 1.0, 0.0);
    run_vec("m100_30", 32'h00640000, 32'h1E000000, 100.0 * Cos30, 50.0);

    // Result and done persist while idle
    repeat (5) @(posedge clock);
    #1;
    check("hold_done", longint'(done), 1, 0);
    check("hold_x", longint'(x), q16(100.0 * Cos30), Tol);

    // Outputs keep the old result while the next conversion runs
    mod   = 32'h00020000;
    angle = 32'hD3000000;
    pulse_start();
    repeat (3) @(posedge clock);
    #1;
    check("busy_keeps_y", longint'(y), q16(50.0), Tol);
    wait_done(-1, 0, cyc);
    check("m2_n45_latency", cyc, 29, 0);
    check("m2_n45_x", longint'(x), q16(Rt2), Tol);
    check("m2_n45_y", longint'(y), q16(-Rt2), Tol);

    // Enable low for 10 cycles mid-run delays done by exactly 10
    mod   = 32'h00640000;
    angle = 32'h1E000000;
    pulse_start();
    wait_done(5, 10, cyc);
    check("gap_latency", cyc, 42, 0);
    check("gap_x", longint'(x), q16(100.0 * Cos30), Tol);
    check("gap_y", longint'(y), q16(50.0), Tol);

    // Restart at iteration 12 with new operands
    mod   = 32'h00010000;
    angle = 32'h00000000;
    pulse_start();
    repeat (12) @(posedge clock);
    #1;
    check("restart_pre_done", longint'(done), 0, 0);
    mod   = 32'h00020000;
    angle = 32'hD3000000;
    pulse_start();
    check("restart_done_at_load", longint'(done), 0, 0);
    wait_done(-1, 0, cyc);
    check("restart_latency", cyc, 32, 0);
    check("restart_x", longint'(x), q16(Rt2), Tol);
    check("restart_y", longint'(y), q16(-Rt2), Tol);

    // Reset at iteration 20, asserted together with start: reset wins
    mod   = 32'h00640000;
    angle = 32'h1E000000;
    pulse_start();
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_x", longint'(x), 0, 0);
    check("rst_y", longint'(y), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    repeat (40) @(posedge clock);
    #1;
    check("rst_start_ignored", longint'(done), 0, 0);

    run_vec("unit_90", 32'h00010000, 32'h5A000000, 0.0, 1.0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pol2rec.md
# pol2rec

Converts polar coordinates (modulus 16Q16, angle in degrees 8Q24) to rectangular X/Y (16Q16) using CORDIC in rotation mode. It is the inverse companion of the rectangular-to-polar converter and shares its clocking, enable/start protocol and number formats. Results of the polar converter can be fed straight back for round-trip checks. The block iterates serially, one micro-rotation per enabled clock, with a registered result and a `done` flag.

## Interface
- `NITER`, 32: number of CORDIC iterations (1..32).
- `clock` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `enable` input 1: set and keep high to enable iteration. Low freezes all iteration state.
- `start` input 1: single-cycle pulse; loads operands and starts a conversion.
- `mod` input 32 signed: modulus, 16Q16, range [0, 32767].
- `angle` input 32 signed: angle, degrees 8Q24, range [-90.0, +90.0].
- `x` output 32 signed: mod·cos(angle), 16Q16, registered.
- `y` output 32 signed: mod·sin(angle), 16Q16, registered.
- `done` output 1: high while `x`/`y` hold the result of the last completed conversion.

## Operation
- States: IDLE, RUN. Reset → IDLE; `x`=0, `y`=0, `done`=0, iteration counter=0.
- Load (`start`=1 at an edge, any state, regardless of `enable`): xr=x0, yr=0, zr=`angle`, counter=0, `done`=0, → RUN. `x`/`y` outputs keep their previous values.
- x0 = (`mod`·KINV) >>> 31 with KINV = 32'h4DBA76D4 (0.607252935, 1Q31); 64-bit product, arithmetic shift, truncate to 32 bits.
- Iteration i (RUN, `enable`=1), using atan(2^-i) in degrees 8Q24:
  - zr ≥ 0: xr -= yr>>>i; yr += xr>>>i; zr -= atan_i.
  - zr < 0: xr += yr>>>i; yr -= xr>>>i; zr += atan_i.
  - All updates use pre-iteration values; shifts are arithmetic.
- On the edge that performs iteration NITER−1: `x`=new xr, `y`=new yr, `done`=1, → IDLE.
- `enable`=0 in RUN: no register changes; counter holds.
- `start` during RUN: aborts the current conversion and reloads. `done` stays 0.
- `reset` together with `start`: reset wins.
- Out-of-range inputs: wrap silently; behaviour is undefined but no lock-up.

## Timing
- Start edge T0; iterations occur on the next NITER edges with `enable`=1.
- With `enable` held high: `done` and `x`/`y` update at edge T0+NITER (32 cycles by default).
- `done` stays high until the next `start` or `reset`.
- Accuracy at NITER=32: |error| ≤ 8 LSB on each output.

## Configuration
- `POL2REC_GAIN_COMP_EN` defined: x0 = `mod`·KINV, so outputs are true mod·cos and mod·sin.
- Not defined: x0 = `mod` (no multiplier), so outputs are scaled by K ≈ 1.646760258. The caller must keep `mod` ≤ 19897 to avoid overflow.

## Structure
- Shared package/header:
  - KINV constant
  - NITER default
  - format widths (16Q16, 8Q24)
  - state encoding
- Sub-module `pol2rec_atan_rom`: combinational 5-bit address → 32-bit atan(2^-i) in degrees 8Q24 (entry 0 = 32'h2D000000).
- The iteration counter is inline in the FSM.

## Test plan
- `mod`=32'h00010000, `angle`=0 → after 32 cycles `done`=1, `x`≈32'h00010000, `y`≈0 (±8 LSB).
- `mod`=100.0, `angle`=30.0 (32'h1E000000) → `x`≈32'h00569A40, `y`≈32'h00320000.
- `mod`=2.0, `angle`=−45.0 (32'hD3000000) → `x`≈32'h00016A0A, `y`≈32'hFFFE95F6.
- `angle`=+90.0 with `mod`=1.0 → `x`≈0, `y`≈32'h00010000.
- `enable` toggled low for 10 cycles mid-run → `done` delayed exactly 10 cycles; result identical.
- Second `start` at iteration 12 and `reset` at iteration 20 of separate runs:
  - restart → result of the new operands 32 cycles later;
  - reset → `x`=`y`=0 and `done`=0 on the next edge.
- Build without `POL2REC_GAIN_COMP_EN`: `mod`=1.0, `angle`=0 → `x`≈32'h0001A592.
